gesture_slide_ctrl: RTL and testbench

//  Sits directly downstream of the MTL touch front end: consumes its one-cycle

---
 rtl/gesture_slide_ctrl.sv | 155 +++++++++++++++
 tb/tb_gesture_slide_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gesture_slide_ctrl.sv
// gesture_slide_ctrl: queues West/East gesture pulses and steps the displayed slide index, one load request at a time.
// Latency: a gesture at edge t (queue empty, idle) raises load_req after edge t+1; load_ack at edge a commits cur_idx after edge a.
// Backpressure: gestures are dropped on a full queue (sticky q_ovf); a request is held until load_ack or ACK_TIMEOUT expires.
// Build option: define GEST_SLIDE_WRAP_EN to wrap at the first/last slide instead of saturating.
module gesture_slide_ctrl #(
   parameter int N_SLIDES    = 8,
   parameter int IDX_W       = $clog2(N_SLIDES),
   parameter int QDEPTH      = 4,
   parameter int ACK_TIMEOUT = 50000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             gest_w,
   input  logic             gest_e,
   input  logic             load_ack,
   output logic             load_req,
   output logic [IDX_W-1:0] load_idx,
   output logic [IDX_W-1:0] cur_idx,
   output logic             busy,
   output logic             q_ovf,
   output logic             timeout_err
);

   localparam int QAW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SLIDES - 1);
   localparam logic [QAW:0]     Q_FULL   = (QAW+1)'(QDEPTH);

   typedef enum logic {IDLE, REQ} state_t;

   state_t           state;
   logic [TMR_W-1:0] timer;

   // gesture queue: one bit per entry, 0 = West, 1 = East
   logic             q_mem [QDEPTH];
   logic [QAW-1:0]   q_wr_ptr;
   logic [QAW-1:0]   q_rd_ptr;
   logic [QAW:0]     q_cnt;
   logic             gest_vld;
   logic             q_vld;
   logic             q_full;
   logic             q_pop;
   logic             q_push;
   logic             q_head;
   logic [IDX_W-1:0] nxt_idx;

   // simultaneous opposite gestures cancel each other
   assign gest_vld = gest_w ^ gest_e;
   assign q_vld    = (q_cnt != '0);
   assign q_full   = (q_cnt == Q_FULL);
   assign q_pop    = q_vld && (state == IDLE);
   // a full queue still accepts when the head leaves in the same cycle
   assign q_push   = gest_vld && (!q_full || q_pop);
   assign q_head   = q_mem[q_rd_ptr];
   assign busy     = (state != IDLE) || q_vld;

   // queue storage, no reset needed: entries are only read while counted valid
   always_ff @(posedge clk) begin
      if (q_push) q_mem[q_wr_ptr] <= gest_e;
   end

   // queue pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         q_wr_ptr <= '0;
         q_rd_ptr <= '0;
         q_cnt    <= '0;
      end else begin
         if (q_push) q_wr_ptr <= q_wr_ptr + 1'b1;
         if (q_pop)  q_rd_ptr <= q_rd_ptr + 1'b1;
         case ({q_push, q_pop})
            2'b10:   q_cnt <= q_cnt + 1'b1;
            2'b01:   q_cnt <= q_cnt - 1'b1;
            default: q_cnt <= q_cnt;
         endcase
      end
   end

   // sticky flag: a gesture was lost because the queue had no room
   always_ff @(posedge clk) begin
      if (rst)                     q_ovf <= 1'b0;
      else if (gest_vld && !q_push) q_ovf <= 1'b1;
   end

   // target index for the queue head; edge behaviour depends on build option
   always_comb begin
      nxt_idx = cur_idx;
      if (q_head) begin
         if (cur_idx == IDX_LAST) begin
`ifdef GEST_SLIDE_WRAP_EN
            nxt_idx = '0;
`else
            nxt_idx = cur_idx;
`endif
         end else begin
            nxt_idx = cur_idx + 1'b1;
         end
      end else begin
         if (cur_idx == '0) begin
`ifdef GEST_SLIDE_WRAP_EN
            nxt_idx = IDX_LAST;
`else
            nxt_idx = cur_idx;
`endif
         end else begin
            nxt_idx = cur_idx - 1'b1;
         end
      end
   end

   // request FSM: issue one load per index change, commit on ack, abort on timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         load_req    <= 1'b0;
         load_idx    <= '0;
         cur_idx     <= '0;
         timer       <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               // popped gestures that do not move the index are simply consumed
               if (q_vld && (nxt_idx != cur_idx)) begin
                  load_idx <= nxt_idx;
                  load_req <= 1'b1;
                  timer    <= '0;
                  state    <= REQ;
               end
            end
            REQ: begin
               // ack takes priority over a timeout in the same cycle
               if (load_ack) begin
                  cur_idx  <= load_idx;
                  load_req <= 1'b0;
                  state    <= IDLE;
               end else if (timer == TMR_LAST) begin
                  load_req    <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               load_req <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gesture_slide_ctrl.sv
// tb_gesture_slide_ctrl: directed vector table, corner-case sequences and randomized run against a queue-based model.
// Uses ACK_TIMEOUT=16 so the timeout path is reachable in a short run.
// Expectations follow GEST_SLIDE_WRAP_EN when that macro is defined for the build.
module tb_gesture_slide_ctrl;

   localparam int N   = 8;
   localparam int W   = 3;
   localparam int QD  = 4;
   localparam int TMO = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         gest_w;
   logic         gest_e;
   logic         load_ack;
   logic         load_req;
   logic [W-1:0] load_idx;
   logic [W-1:0] cur_idx;
   logic         busy;
   logic         q_ovf;
   logic         timeout_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   gesture_slide_ctrl #(
      .N_SLIDES    (N),
      .IDX_W       (W),
      .QDEPTH      (QD),
      .ACK_TIMEOUT (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .gest_w      (gest_w),
      .gest_e      (gest_e),
      .load_ack    (load_ack),
      .load_req    (load_req),
      .load_idx    (load_idx),
      .cur_idx     (cur_idx),
      .busy        (busy),
      .q_ovf       (q_ovf),
      .timeout_err (timeout_err)
   );

   typedef struct packed {
      logic         rst;
      logic         w;
      logic         e;
      logic         ack;
      logic         req;
      logic [W-1:0] lidx;
      logic [W-1:0] cidx;
      logic         busy;
      logic         ovf;
      logic         tmo;
   } vec_t;

   function automatic vec_t mkv(input bit r, input bit w, input bit e, input bit a,
                                input bit q, input int li, input int ci,
                                input bit b, input bit o, input bit t);
      vec_t v;
      v.rst = r; v.w = w; v.e = e; v.ack = a; v.req = q;
      v.lidx = W'(li); v.cidx = W'(ci); v.busy = b; v.ovf = o; v.tmo = t;
      return v;
   endfunction

   function automatic logic [9:0] obs();
      return {load_req, load_idx, cur_idx, busy, q_ovf, timeout_err};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit r, input bit w, input bit e, input bit a);
      rst = r; gest_w = w; gest_e = e; load_ack = a;
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0);
   endtask

   // bounded wait for load_req; a missed request counts as a failed comparison
   task automatic wait_req(input string nm, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (load_req) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: load_req never rose within 30 cycles", nm);
      end
   endtask

   // ---------------- reference model: queue of gestures plus pending request ----------------
   int m_q[$];
   int m_cur, m_tgt, m_age;
   bit m_req, m_ovf, m_tmo;

   function automatic int step_up(input int c);
`ifdef GEST_SLIDE_WRAP_EN
      return (c + 1) % N;
`else
      return (c + 1 < N) ? c + 1 : c;
`endif
   endfunction

   function automatic int step_dn(input int c);
`ifdef GEST_SLIDE_WRAP_EN
      return (c + N - 1) % N;
`else
      return (c > 0) ? c - 1 : 0;
`endif
   endfunction

   // m_age counts how many cycles the current request has been visible
   task automatic model_step(input bit r, input bit w, input bit e, input bit a);
      bit popn;
      int sz, h, n;
      if (r) begin
         m_q.delete();
         m_cur = 0; m_tgt = 0; m_age = 0;
         m_req = 0; m_ovf = 0; m_tmo = 0;
         return;
      end
      m_tmo = 0;
      sz    = m_q.size();
      popn  = !m_req && (sz > 0);
      if (m_req) begin
         if (a) begin
            m_cur = m_tgt;
            m_req = 0;
         end else if (m_age == TMO) begin
            m_req = 0;
            m_tmo = 1;
         end else begin
            m_age++;
         end
      end else if (popn) begin
         h = m_q.pop_front();
         n = (h != 0) ? step_up(m_cur) : step_dn(m_cur);
         if (n != m_cur) begin
            m_tgt = n;
            m_req = 1;
            m_age = 1;
         end
      end
      if (w != e) begin
         if (sz < QD || popn) m_q.push_back(int'(e));
         else                 m_ovf = 1;
      end
   endtask

   function automatic logic [9:0] model_obs();
      return {m_req, W'(m_tgt), W'(m_cur), (m_req || m_q.size() > 0), m_ovf, m_tmo};
   endfunction

   // ---------------- test sequence ----------------
   vec_t vt[12];
   int   ack_pct[4] = '{30, 0, 60, 10};

   initial begin
      bit ok;
      int hi;
      bit r, w, e, a;
      int g;

      drive(1, 0, 0, 0);

      // single-cycle vectors: reset, one East step with delayed ack, ignored ack,
      // cancelled double gesture, one West step
      vt[0]  = mkv(1,0,0,0, 0,0,0,0,0,0);
      vt[1]  = mkv(0,0,1,0, 0,0,0,1,0,0);
      vt[2]  = mkv(0,0,0,0, 1,1,0,1,0,0);
      vt[3]  = mkv(0,0,0,0, 1,1,0,1,0,0);
      vt[4]  = mkv(0,0,0,0, 1,1,0,1,0,0);
      vt[5]  = mkv(0,0,0,1, 0,1,1,0,0,0);
      vt[6]  = mkv(0,0,0,1, 0,1,1,0,0,0);
      vt[7]  = mkv(0,1,1,0, 0,1,1,0,0,0);
      vt[8]  = mkv(0,0,0,0, 0,1,1,0,0,0);
      vt[9]  = mkv(0,1,0,0, 0,1,1,1,0,0);
      vt[10] = mkv(0,0,0,0, 1,0,1,1,0,0);
      vt[11] = mkv(0,0,0,1, 0,0,0,0,0,0);

      for (int i = 0; i < 12; i++) begin
         drive(vt[i].rst, vt[i].w, vt[i].e, vt[i].ack);
         tick();
         chk($sformatf("vec%0d {req,lidx,cidx,busy,ovf,tmo}", i), 32'(obs()),
             32'({vt[i].req, vt[i].lidx, vt[i].cidx, vt[i].busy, vt[i].ovf, vt[i].tmo}));
      end
      drive(0, 0, 0, 0);

      // West at index 0
      do_reset();
      drive(0, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0);
      tick();
`ifdef GEST_SLIDE_WRAP_EN
      chk("w_at_0 load_req", 32'(load_req), 32'd1);
      chk("w_at_0 load_idx", 32'(load_idx), 32'd7);
      drive(0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0);
      chk("w_at_0 cur_idx after ack", 32'(cur_idx), 32'd7);
`else
      tick();
      chk("w_at_0 load_req", 32'(load_req), 32'd0);
      chk("w_at_0 cur_idx", 32'(cur_idx), 32'd0);
      chk("w_at_0 busy", 32'(busy), 32'd0);
`endif

      // six back-to-back East pulses with ack withheld: one in flight, four queued, one dropped
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 1, 0);
         tick();
      end
      drive(0, 0, 0, 0);
      chk("burst q_ovf", 32'(q_ovf), 32'd1);
      chk("burst load_req", 32'(load_req), 32'd1);
      chk("burst load_idx", 32'(load_idx), 32'd1);
      for (int k = 1; k <= 5; k++) begin
         wait_req($sformatf("burst req%0d", k), ok);
         if (ok) begin
            chk($sformatf("burst req%0d load_idx", k), 32'(load_idx), 32'(k));
            drive(0, 0, 0, 1);
            tick();
            drive(0, 0, 0, 0);
            chk($sformatf("burst ack%0d cur_idx", k), 32'(cur_idx), 32'(k));
            chk($sformatf("burst ack%0d load_req", k), 32'(load_req), 32'd0);
         end
      end
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (load_req) hi++;
      end
      chk("burst extra requests", 32'(hi), 32'd0);
      chk("burst final cur_idx", 32'(cur_idx), 32'd5);
      chk("burst busy idle", 32'(busy), 32'd0);

      // timeout: request visible exactly TMO cycles, one-cycle error pulse
      do_reset();
      chk("tmo q_ovf cleared", 32'(q_ovf), 32'd0);
      drive(0, 0, 1, 0);
      tick();
      drive(0, 0, 0, 0);
      wait_req("tmo req", ok);
      hi = 0;
      for (int i = 0; i < 40 && load_req; i++) begin
         hi++;
         tick();
      end
      chk("tmo load_req cycles", 32'(hi), 32'(TMO));
      chk("tmo err pulse", 32'(timeout_err), 32'd1);
      chk("tmo cur_idx kept", 32'(cur_idx), 32'd0);
      tick();
      chk("tmo err one cycle", 32'(timeout_err), 32'd0);

      // ack on the final allowed cycle beats the timeout
      drive(0, 0, 1, 0);
      tick();
      drive(0, 0, 0, 0);
      wait_req("late ack req", ok);
      for (int i = 0; i < TMO - 1; i++) tick();
      chk("late ack still requesting", 32'(load_req), 32'd1);
      drive(0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0);
      chk("late ack cur_idx", 32'(cur_idx), 32'd1);
      chk("late ack no err", 32'(timeout_err), 32'd0);
      chk("late ack load_req", 32'(load_req), 32'd0);

      // reset while a request is in flight and two gestures are queued
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 0);
         tick();
      end
      drive(0, 0, 0, 0);
      chk("mid rst pre load_req", 32'(load_req), 32'd1);
      drive(1, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0);
      chk("mid rst outputs", 32'(obs()), 32'd0);
      hi = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (load_req || busy) hi++;
      end
      chk("mid rst queue discarded", 32'(hi), 32'd0);

      // randomized traffic against the model, ack rate varying by phase
      for (int c = 0; c < 4000; c++) begin
         r = (c == 0) || ($urandom_range(0, 699) == 0);
         g = $urandom_range(0, 9);
         w = (g < 2) || (g == 4);
         e = (g == 2) || (g == 3) || (g == 4);
         a = ($urandom_range(0, 99) < ack_pct[c / 1000]);
         drive(r, w, e, a);
         @(posedge clk);
         model_step(r, w, e, a);
         #1;
         chk($sformatf("rand cyc%0d {req,lidx,cidx,busy,ovf,tmo}", c), 32'(obs()), 32'(model_obs()));
      end
      drive(0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
